// File: rtl/pb_io_master.sv
// pb_io_master: valid/ready command initiator for the 8-bit port bus; optional interrupt service via PB_IO_MASTER_IRQ_EN.
module pb_io_master #(
  parameter logic [7:0] IRQ_STATUS_ADDR = 8'h00,
  parameter logic [7:0] IRQ_CLEAR_ADDR  = 8'h01,
  parameter logic [7:0] IRQ_CLEAR_DATA  = 8'h01
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic       cmd_write,
  input  logic [7:0] cmd_addr,
  input  logic [7:0] cmd_wdata,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic [7:0] rsp_rdata,
  output logic [7:0] port_id,
  output logic [7:0] out_port,
  input  logic [7:0] in_port,
  output logic       write_strobe,
  output logic       read_strobe,
  input  logic       interrupt,
  output logic       irq_valid,
  output logic [7:0] irq_status
);
  typedef enum logic [3:0] {
    IDLE, SETUP, STROBE, RESP
`ifdef PB_IO_MASTER_IRQ_EN
    , IRQ_RD_SETUP, IRQ_RD_STB, IRQ_WR_SETUP, IRQ_WR_STB, HOLDOFF
`endif
  } state_t;
  state_t state;
  logic   is_write;
`ifdef PB_IO_MASTER_IRQ_EN
  logic   hold;
  // interrupt service wins over a command presented in the same idle cycle
  assign cmd_ready = state == IDLE && !interrupt;
`else
  logic   unused_irq;
  assign unused_irq = interrupt;
  assign cmd_ready  = state == IDLE;
  assign irq_valid  = 1'b0;
  assign irq_status = 8'h00;
`endif
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      is_write     <= 1'b0;
      port_id      <= 8'h00;
      out_port     <= 8'h00;
      rsp_rdata    <= 8'h00;
      rsp_valid    <= 1'b0;
      write_strobe <= 1'b0;
      read_strobe  <= 1'b0;
`ifdef PB_IO_MASTER_IRQ_EN
      irq_valid    <= 1'b0;
      irq_status   <= 8'h00;
      hold         <= 1'b0;
`endif
    end else begin
      write_strobe <= 1'b0;
      read_strobe  <= 1'b0;
`ifdef PB_IO_MASTER_IRQ_EN
      irq_valid    <= 1'b0;
`endif
      case (state)
        IDLE:
`ifdef PB_IO_MASTER_IRQ_EN
          if (interrupt) begin
            port_id <= IRQ_STATUS_ADDR;
            state   <= IRQ_RD_SETUP;
          end else
`endif
          if (cmd_valid) begin
            is_write <= cmd_write;
            port_id  <= cmd_addr;
            out_port <= cmd_wdata;
            state    <= SETUP;
          end
        SETUP: begin
          write_strobe <= is_write;
          read_strobe  <= !is_write;
          state        <= STROBE;
        end
        STROBE:
          if (is_write) state <= IDLE;
          else begin
            rsp_rdata <= in_port;
            rsp_valid <= 1'b1;
            state     <= RESP;
          end
        RESP:
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= IDLE;
          end
`ifdef PB_IO_MASTER_IRQ_EN
        IRQ_RD_SETUP: begin
          read_strobe <= 1'b1;
          state       <= IRQ_RD_STB;
        end
        IRQ_RD_STB: begin
          irq_status <= in_port;
          port_id    <= IRQ_CLEAR_ADDR;
          out_port   <= IRQ_CLEAR_DATA;
          state      <= IRQ_WR_SETUP;
        end
        IRQ_WR_SETUP: begin
          write_strobe <= 1'b1;
          state        <= IRQ_WR_STB;
        end
        IRQ_WR_STB: begin
          irq_valid <= 1'b1;
          hold      <= 1'b0;
          state     <= HOLDOFF;
        end
        HOLDOFF: begin
          hold <= 1'b1;
          if (hold) state <= IDLE;
        end
`endif
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_pb_io_master.sv
// tb_pb_io_master: randomized port-bus transactions checked against a memory-map reference model.
module tb_pb_io_master;
  logic       clk = 0, reset = 1;
  logic       cmd_valid = 0, cmd_ready, cmd_write = 0;
  logic [7:0] cmd_addr = 0, cmd_wdata = 0;
  logic       rsp_valid, rsp_ready = 0;
  logic [7:0] rsp_rdata, port_id, out_port, in_port;
  logic       write_strobe, read_strobe, interrupt = 0, irq_valid;
  logic [7:0] irq_status;
  logic [7:0] mem [256];
  logic [7:0] seed [256];
  logic [7:0] ref_mem [256];
  logic       preload = 1, mon_en = 0;
  logic [7:0] prev_pid = 0;
  int         tests = 0, fails = 0;

  pb_io_master dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_write(cmd_write), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .port_id(port_id), .out_port(out_port), .in_port(in_port),
    .write_strobe(write_strobe), .read_strobe(read_strobe),
    .interrupt(interrupt), .irq_valid(irq_valid), .irq_status(irq_status)
  );

  always #5 clk = ~clk;

  // responder: plain register file on the bus
  assign in_port = mem[port_id];
  always @(posedge clk)
    if (preload) for (int i = 0; i < 256; i++) mem[i] <= seed[i];
    else if (write_strobe) mem[port_id] <= out_port;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  always @(negedge clk) if (mon_en) begin
    chk("one_strobe", {31'd0, write_strobe & read_strobe}, 0);
    chk("strobe_pid_stable", {31'd0, (write_strobe | read_strobe) && port_id != prev_pid}, 0);
    prev_pid = port_id;
  end

  task automatic do_write(input logic [7:0] a, input logic [7:0] d);
    chk("wr_ready", cmd_ready, 1);
    cmd_valid = 1; cmd_write = 1; cmd_addr = a; cmd_wdata = d;
    @(negedge clk); cmd_valid = 0;
    chk("wr_setup_pid", port_id, a);
    chk("wr_setup_stb", {write_strobe, read_strobe}, 0);
    chk("wr_busy", cmd_ready, 0);
    @(negedge clk);
    chk("wr_stb", {write_strobe, read_strobe}, 2'b10);
    chk("wr_pid", port_id, a);
    chk("wr_data", out_port, d);
    ref_mem[a] = d;
    @(negedge clk);
    chk("wr_done_ready", cmd_ready, 1);
    chk("wr_done_stb", {write_strobe, read_strobe}, 0);
    chk("wr_no_rsp", rsp_valid, 0);
  endtask

  task automatic do_read(input logic [7:0] a, input int stall);
    logic [7:0] exp;
    chk("rd_ready", cmd_ready, 1);
    cmd_valid = 1; cmd_write = 0; cmd_addr = a; cmd_wdata = 8'($urandom);
    @(negedge clk); cmd_valid = 0;
    chk("rd_setup_pid", port_id, a);
    chk("rd_setup_stb", {write_strobe, read_strobe}, 0);
    @(negedge clk);
    chk("rd_stb", {write_strobe, read_strobe}, 2'b01);
    chk("rd_pid", port_id, a);
    exp = ref_mem[a];
    @(negedge clk);
    chk("rd_valid", rsp_valid, 1);
    chk("rd_data", rsp_rdata, exp);
    chk("rd_busy", cmd_ready, 0);
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      chk("rd_hold_valid", rsp_valid, 1);
      chk("rd_hold_data", rsp_rdata, exp);
      chk("rd_hold_busy", cmd_ready, 0);
    end
    rsp_ready = 1;
    @(negedge clk);
    rsp_ready = 0;
    chk("rd_done_valid", rsp_valid, 0);
    chk("rd_done_ready", cmd_ready, 1);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      seed[i] = 8'($urandom);
      ref_mem[i] = seed[i];
    end
    repeat (2) @(negedge clk);
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_strobes", {write_strobe, read_strobe}, 0);
    chk("rst_port_id", port_id, 0);
    chk("rst_out_port", out_port, 0);
    chk("rst_rsp_rdata", rsp_rdata, 0);
    chk("rst_irq", {irq_valid, irq_status}, 0);
    preload = 0; reset = 0; mon_en = 1;
    @(negedge clk);
    do_write(8'h03, 8'h5A);
    do_write(8'h02, 8'hC3);
    do_read(8'h02, 0);
    do_read(8'h03, 5);
    for (int n = 0; n < 60; n++) begin
      if ($urandom_range(0, 1) == 1) do_write(8'($urandom_range(0, 7)), 8'($urandom));
      else do_read(8'($urandom_range(0, 7)), int'($urandom_range(0, 3)));
    end
`ifdef PB_IO_MASTER_IRQ_EN
    interrupt = 1;
    cmd_valid = 1; cmd_write = 1; cmd_addr = 8'h05; cmd_wdata = 8'hA7;
    #1 chk("irq_blocks_cmd", cmd_ready, 0);
    @(negedge clk);
    chk("irq_rd_pid", port_id, 8'h00);
    chk("irq_rd_setup", {write_strobe, read_strobe}, 0);
    @(negedge clk);
    chk("irq_rd_stb", {write_strobe, read_strobe}, 2'b01);
    @(negedge clk);
    chk("irq_wr_pid", port_id, 8'h01);
    chk("irq_wr_data", out_port, 8'h01);
    chk("irq_wr_setup", {write_strobe, read_strobe}, 0);
    @(negedge clk);
    chk("irq_wr_stb", {write_strobe, read_strobe}, 2'b10);
    interrupt = 0;
    @(negedge clk);
    chk("irq_valid", irq_valid, 1);
    chk("irq_status", irq_status, ref_mem[0]);
    chk("irq_hold1", cmd_ready, 0);
    ref_mem[1] = 8'h01;
    @(negedge clk);
    chk("irq_pulse_end", irq_valid, 0);
    chk("irq_hold2", cmd_ready, 0);
    @(negedge clk);
    chk("irq_cmd_ready", cmd_ready, 1);
    @(negedge clk); cmd_valid = 0;
    chk("irq_cmd_pid", port_id, 8'h05);
    @(negedge clk);
    chk("irq_cmd_stb", {write_strobe, read_strobe}, 2'b10);
    ref_mem[5] = 8'hA7;
    @(negedge clk);
    do_read(8'h01, 0);
`else
    interrupt = 1;
    do_write(8'h07, 8'h3C);
    chk("irq_ignored", {irq_valid, irq_status}, 0);
    interrupt = 0;
`endif
    cmd_valid = 1; cmd_write = 0; cmd_addr = 8'h06;
    @(negedge clk); cmd_valid = 0;
    @(negedge clk);
    chk("rst_mid_stb", read_strobe, 1);
    reset = 1;
    @(negedge clk);
    chk("rst_mid_strobes", {write_strobe, read_strobe}, 0);
    chk("rst_mid_rsp", rsp_valid, 0);
    chk("rst_mid_pid", port_id, 0);
    reset = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("rst_no_rsp", rsp_valid, 0);
      chk("rst_idle_ready", cmd_ready, 1);
    end
    do_read(8'h06, 1);
    for (int i = 0; i < 8; i++) chk("mem_final", mem[i], ref_mem[i]);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
